// File: rtl/halflife_pkg.sv
// Shared types and constants for the half-life decay timer.
// Holds the FSM state encoding and the decay-mode selector values.
package halflife_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_HALVE  = 1'b0;
   localparam logic MODE_LINEAR = 1'b1;

endpackage

// File: rtl/halflife_prescaler.sv
// Decay-period prescaler: counts 0..P-1 with P = max(period,1).
// Raises tc on the last count while enabled, then wraps to 0 on the same edge.
module halflife_prescaler #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                tc
);

   localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

   logic [PERIOD_W-1:0] count;
   logic [PERIOD_W-1:0] last;

   // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
   always_comb begin
      last = (period == '0) ? '0 : period - ONE;
   end

   assign tc = enable & (count == last);

   // A shortened period below the current count simply runs on to all-ones and wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tc ? '0 : count + ONE;
      end
   end

endmodule

// File: rtl/halflife_timer_n.sv
// Half-life timer: a WIDTH-bit quantity that is loaded, nudged by up/down edges,
// and decays every programmable period by halving or by decrementing.
module halflife_timer_n
   import halflife_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PERIOD_W = 16,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                load,
   input  logic [WIDTH-1:0]    load_val,
   input  logic                up,
   input  logic                down,
   input  logic                mode,
   input  logic [PERIOD_W-1:0] period,
   output logic [WIDTH-1:0]    value,
   output logic [CNT_W-1:0]    n_elapsed,
   output logic                tick,
   output logic                busy,
   output logic                done
);

   localparam logic [WIDTH-1:0] V_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] N_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic             up_q;
   logic             down_q;
   logic             up_e;
   logic             down_e;
   logic             tc;
   logic             decay;
   logic             run_hold;
   logic [WIDTH-1:0] adj;
   logic [WIDTH-1:0] nxt;

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
      return (x == '1) ? x : x + V_ONE;
   endfunction

   function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] x);
      return (x == '0) ? x : x - V_ONE;
   endfunction

   assign up_e   = up & ~up_q;
   assign down_e = down & ~down_q;

   // A decay only lands when no higher-priority control claims the cycle.
   assign decay    = tc & ~load & ~stop;
   assign run_hold = (state == RUN) & ~load & ~stop & (nxt != '0);

   always_comb begin
      adj = value;
      if (up_e && !down_e) begin
         adj = sat_inc(value);
      end else if (down_e && !up_e) begin
         adj = sat_dec(value);
      end
      nxt = adj;
      if (decay) begin
         nxt = (mode == MODE_LINEAR) ? sat_dec(adj) : (adj >> 1);
      end
   end

   // Prescaler restarts from 0 whenever RUN is entered, left, or not occupied.
   halflife_prescaler #(
      .PERIOD_W(PERIOD_W)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (~run_hold),
      .enable (state == RUN),
      .period (period),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         value     <= '0;
         n_elapsed <= '0;
         up_q      <= 1'b0;
         down_q    <= 1'b0;
         tick      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         up_q   <= up;
         down_q <= down;
         tick   <= decay;
         case (state)
            IDLE: begin
               if (load) begin
                  value     <= load_val;
                  n_elapsed <= '0;
               end else if (stop) begin
                  value <= value;
               end else if (start) begin
                  if (value != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  value <= adj;
               end
            end
            RUN: begin
               if (load) begin
                  value     <= load_val;
                  n_elapsed <= '0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  value <= nxt;
                  if (decay && (n_elapsed != '1)) begin
                     n_elapsed <= n_elapsed + N_ONE;
                  end
                  if (nxt == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (load) begin
                  value     <= load_val;
                  n_elapsed <= '0;
                  state     <= IDLE;
                  done      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_halflife_timer_n.sv
// Vector-table bench for halflife_timer_n with a queue scoreboard of expected outputs.
module tb_halflife_timer_n;

   typedef struct {
      string       nm;
      logic        st, sp, ld;
      logic [7:0]  lv;
      logic        u, d, md;
      logic [15:0] per;
      logic [7:0]  ev;
      logic [3:0]  en;
      logic        tk, bz, dn;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, load = 1'b0;
   logic [7:0]  load_val = '0;
   logic        up = 1'b0, down = 1'b0, mode = 1'b0;
   logic [15:0] period = 16'd3;
   logic [7:0]  value;
   logic [3:0]  n_elapsed;
   logic        tick, busy, done;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   halflife_timer_n #(.WIDTH(8), .PERIOD_W(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
      .load_val(load_val), .up(up), .down(down), .mode(mode), .period(period),
      .value(value), .n_elapsed(n_elapsed), .tick(tick), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(string nm, bit st, bit sp, bit ld, int lv, bit u, bit d,
                               bit md, int per, int ev, int en, bit tk, bit bz, bit dn);
      vec_t v;
      v.nm = nm; v.st = st; v.sp = sp; v.ld = ld; v.lv = lv[7:0];
      v.u = u; v.d = d; v.md = md; v.per = per[15:0];
      v.ev = ev[7:0]; v.en = en[3:0]; v.tk = tk; v.bz = bz; v.dn = dn;
      return v;
   endfunction

   task automatic check_out(string nm, logic [7:0] ev, logic [3:0] en, logic tk, logic bz, logic dn);
      checks++;
      if ({value, n_elapsed, tick, busy, done} !== {ev, en, tk, bz, dn}) begin
         errors++;
         $display("FAIL %s: got value=%0d n=%0d tick=%b busy=%b done=%b, want value=%0d n=%0d tick=%b busy=%b done=%b",
                  nm, value, n_elapsed, tick, busy, done, ev, en, tk, bz, dn);
      end
   endtask

   // Scoreboard consumer: one expected record per clock edge, sampled just after it.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         vec_t e;
         e = exp_q.pop_front();
         check_out(e.nm, e.ev, e.en, e.tk, e.bz, e.dn);
      end
   end

   task automatic step(input vec_t t);
      @(negedge clk);
      start = t.st; stop = t.sp; load = t.ld; load_val = t.lv;
      up = t.u; down = t.d; mode = t.md; period = t.per;
      exp_q.push_back(t);
      @(posedge clk);
      #2;
   endtask

   initial begin
      int seq[9] = '{200, 100, 50, 25, 12, 6, 3, 1, 0};

      // halving run, 200 -> 0 with period 3
      tbl.push_back(mk("ld200",   0,0,1,200, 0,0,0,3, 200,0,0,0,0));
      tbl.push_back(mk("st_halve",1,0,0,0,   0,0,0,3, 200,0,0,1,0));
      for (int k = 1; k <= 8; k++) begin
         for (int j = 1; j <= 3; j++) begin
            bit last;
            last = (j == 3);
            tbl.push_back(mk("halve", 0,0,0,0, 0,0,0,3,
                             last ? seq[k] : seq[k-1], last ? k : k-1,
                             last, !(last && k == 8), last && k == 8));
         end
      end
      tbl.push_back(mk("done_hold",0,0,0,0, 0,0,0,3, 0,8,0,0,1));
      tbl.push_back(mk("done_ign", 1,0,0,0, 1,0,0,3, 0,8,0,0,1));
      tbl.push_back(mk("done_ign2",0,1,0,0, 0,1,0,3, 0,8,0,0,1));
      // linear run with period 0
      tbl.push_back(mk("ld5",     0,0,1,5, 0,0,1,0, 5,0,0,0,0));
      tbl.push_back(mk("st_lin",  1,0,0,0, 0,0,1,0, 5,0,0,1,0));
      for (int i = 1; i <= 5; i++)
         tbl.push_back(mk("linear", 0,0,0,0, 0,0,1,0, 5-i, i, 1, i < 5, i == 5));
      tbl.push_back(mk("lin_done",0,0,0,0, 0,0,1,0, 0,5,0,0,1));
      // up/down edge handling in IDLE
      tbl.push_back(mk("ld254",   0,0,1,254, 0,0,0,3, 254,0,0,0,0));
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk("up_hold", 0,0,0,0, 1,0,0,3, 255,0,0,0,0));
      tbl.push_back(mk("up_rel",  0,0,0,0, 0,0,0,3, 255,0,0,0,0));
      tbl.push_back(mk("up_sat",  0,0,0,0, 1,0,0,3, 255,0,0,0,0));
      tbl.push_back(mk("up_rel2", 0,0,0,0, 0,0,0,3, 255,0,0,0,0));
      tbl.push_back(mk("dn",      0,0,0,0, 0,1,0,3, 254,0,0,0,0));
      tbl.push_back(mk("dn_rel",  0,0,0,0, 0,0,0,3, 254,0,0,0,0));
      tbl.push_back(mk("updn",    0,0,0,0, 1,1,0,3, 254,0,0,0,0));
      tbl.push_back(mk("updn_rel",0,0,0,0, 0,0,0,3, 254,0,0,0,0));
      tbl.push_back(mk("ld0",     0,0,1,0, 0,0,0,3, 0,0,0,0,0));
      tbl.push_back(mk("dn_sat",  0,0,0,0, 0,1,0,3, 0,0,0,0,0));
      tbl.push_back(mk("st_zero", 1,0,0,0, 0,0,0,3, 0,0,0,0,1));
      // adjust on the decay cycle, stop, restart, load in RUN
      tbl.push_back(mk("ld9",     0,0,1,9, 0,0,0,3, 9,0,0,0,0));
      tbl.push_back(mk("st9",     1,0,0,0, 0,0,0,3, 9,0,0,1,0));
      tbl.push_back(mk("run9a",   0,0,0,0, 0,0,0,3, 9,0,0,1,0));
      tbl.push_back(mk("run9b",   0,0,0,0, 0,0,0,3, 9,0,0,1,0));
      tbl.push_back(mk("adj_decay",0,0,0,0,1,0,0,3, 5,1,1,1,0));
      tbl.push_back(mk("run5",    0,0,0,0, 0,0,0,3, 5,1,0,1,0));
      tbl.push_back(mk("stop",    0,1,0,0, 0,0,0,3, 5,1,0,0,0));
      tbl.push_back(mk("restart", 1,0,0,0, 0,0,0,3, 5,1,0,1,0));
      tbl.push_back(mk("rs_a",    0,0,0,0, 0,0,0,3, 5,1,0,1,0));
      tbl.push_back(mk("rs_b",    0,0,0,0, 0,0,0,3, 5,1,0,1,0));
      tbl.push_back(mk("full_P",  0,0,0,0, 0,0,0,3, 2,2,1,1,0));
      tbl.push_back(mk("run_dn",  0,0,0,0, 0,1,0,3, 1,2,0,1,0));
      tbl.push_back(mk("run_dn2", 0,0,0,0, 0,0,0,3, 1,2,0,1,0));
      tbl.push_back(mk("halve1",  0,0,0,0, 0,0,0,3, 0,3,1,0,1));
      tbl.push_back(mk("ld50",    0,0,1,50, 0,0,0,3, 50,0,0,0,0));
      tbl.push_back(mk("st50",    1,0,0,0, 0,0,0,3, 50,0,0,1,0));
      tbl.push_back(mk("ld_run",  0,0,1,77, 0,0,0,3, 77,0,0,0,0));

      // reset state
      #3;
      check_out("reset", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // asynchronous reset between edges while running
      step(mk("st77", 1,0,0,0, 0,0,0,3, 77,0,0,1,0));
      step(mk("run77",0,0,0,0, 0,0,0,3, 77,0,0,1,0));
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(mk("post_rst",   0,0,0,0, 0,0,0,3, 0,0,0,0,0));
      step(mk("st_zero_rst",1,0,0,0, 0,0,0,3, 0,0,0,0,1));
      step(mk("ld_done",    0,0,1,3, 0,0,0,3, 3,0,0,0,0));

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected records left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/halflife_timer_n.md
Name: halflife_timer_n

Overview:
- Parametrised successor to the 4-bit half-life counter.
- Holds a WIDTH-bit quantity that can be loaded or nudged up and down, and decays on a programmable period, either by halving (exponential) or by decrementing (linear).
- Counts the decay periods elapsed and flags when the quantity reaches zero.
- Sits directly under the Tiny Tapeout wrapper; the wrapper maps ui_in/uio_in/uo_out onto these ports.

Parameters:
- WIDTH, 8: width of the quantity (load_val, value).
- PERIOD_W, 16: width of the decay-period input and the internal prescaler.
- CNT_W, 4: width of the elapsed-period counter n_elapsed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins or resumes decay.
- stop  in  1  level; pauses decay.
- load  in  1  level; loads load_val.
- load_val  in  WIDTH  value captured by load.
- up  in  1  increment request; acts on its rising edge.
- down  in  1  decrement request; acts on its rising edge.
- mode  in  1  0 = halve per period, 1 = subtract 1 per period; sampled on every tick.
- period  in  PERIOD_W  decay period in clk cycles; 0 is treated as 1.
- value  out  WIDTH  current quantity.
- n_elapsed  out  CNT_W  decay periods elapsed since the last load; saturates at all-ones.
- tick  out  1  one-cycle pulse, high in the cycle after a decay was applied.
- busy  out  1  high in state RUN.
- done  out  1  high in state DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; value, n_elapsed, prescaler and the up/down edge registers = 0; tick=busy=done=0.
- Inputs are synchronous to clk; synchronisers belong to the wrapper.
- Edge detect: up_e = up & ~up_q, down_e = down & ~down_q, with up_q/down_q registered every cycle.
- Priority per cycle: load > stop > start > up/down adjust and decay.
- State machine, 3 states:
  - IDLE:
    - load: value=load_val, n_elapsed=0, prescaler=0; stay in IDLE.
    - start with value!=0: go to RUN, prescaler=0.
    - start with value==0: go to DONE.
    - up_e/down_e: adjust value.
  - RUN:
    - Prescaler counts 0..P-1, where P=max(period,1).
    - Decay event when prescaler==P-1; the prescaler wraps to 0 on the same edge.
    - The first decay event occurs P cycles after entering RUN.
    - stop: go to IDLE; prescaler cleared; value and n_elapsed held.
    - load: value=load_val, n_elapsed=0, go to IDLE.
    - Next value is computed as adj = value+1 if up_e only, value-1 if down_e only, value unchanged if both or neither. Increment saturates at 2^WIDTH-1; decrement saturates at 0.
    - If a decay event occurs: next = mode ? sat_dec(adj) : adj>>1, and n_elapsed increments, saturating. Otherwise next = adj.
    - If next==0: go to DONE on the same edge.
  - DONE:
    - value holds 0; prescaler held at 0.
    - up_e, down_e, start and stop are ignored.
    - Only load leaves DONE; it goes to IDLE. Loading 0 still goes to IDLE.
- tick: registered; high for exactly one cycle after each decay event, including the event that enters DONE.
- busy = (state==RUN); done = (state==DONE). Both are registered decodes with no extra latency beyond the state register.
- A change of period while in RUN takes effect on the next compare. If the new P-1 is below the current prescaler count, the prescaler continues up to all-ones and wraps; it must not lock.
- In halve mode, value 1 decays to 0, and from there the block enters DONE.

Decomposition:
- Shared package halflife_pkg: state enum typedef {IDLE, RUN, DONE}; localparam MODE_HALVE=1'b0, MODE_LINEAR=1'b1.
- One sub-module, halflife_prescaler: PERIOD_W counter with clear/enable inputs and a terminal-count output.
- The FSM, edge detectors and datapath stay in halflife_timer_n.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, state IDLE.
- Halving run: load_val=200, period=3, mode=0, start.
  - value sequence 100, 50, 25, 12, 6, 3, 1, 0, one step every 3 cycles.
  - tick fires 8 times.
  - n_elapsed saturates at 15? No: it ends at 8 (CNT_W=4).
  - done=1 after the step that reaches 0; busy=0.
- Linear mode with period=0: load 5, mode=1, start -> value decrements every cycle: 4, 3, 2, 1, 0; done high 5 cycles after start.
- Up/down edges: in IDLE with value=254, hold up high for 10 cycles -> value=255 only once.
  - A further up pulse keeps 255 (saturated).
  - up and down rising on the same cycle -> value unchanged.
- Adjust coinciding with decay: RUN, value=9, up_e on the decay cycle with mode=0 -> value=5 ((9+1)>>1).
- Control edges:
  - start with value=0 -> DONE next cycle.
  - stop mid-period -> value held, busy=0.
  - start again -> next decay a full P cycles later.
  - load during DONE -> IDLE, n_elapsed=0.
